// File: rtl/tcm_port_arbiter_pkg.sv
// Shared types and defaults for the TCM port arbiter.
// Owner tags, request bundle and the default starvation limit.
package tcm_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } tcm_req_t;

endpackage

// File: rtl/tcm_port_arbiter_if.sv
// Requester-side TCM port: valid/ready request channel
// plus an unconditional one-cycle response.
interface tcm_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_we;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid,
    output req_addr,
    output req_we,
    output req_wstrb,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_we,
    input  req_wstrb,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/tcm_port_arbiter_starve_ctr.sv
// Saturating count of cycles m1 waited behind m0;
// force_m1 is raised once the count hits LIMIT.
module tcm_arb_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic       force_m1,
  output logic [7:0] count
);

  localparam logic [7:0] LIM = 8'(LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (inc && count != LIM) begin
      count <= count + 8'd1;
    end
  end

  assign force_m1 = (count == LIM);

endmodule

// File: rtl/tcm_port_arbiter.sv
// Two-requester arbiter in front of a single-port TCM:
// m0 priority, m1 anti-starvation and exclusive lock.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  tcm_port_arbiter_if.slave       m0,
  tcm_port_arbiter_if.slave       m1,
  input  logic                    m1_lock,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-3:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [7:0]              starve_cnt_o
);

  tcm_req_t r0, r1, win;
  logic     force_m1;
  logic     gnt0, gnt1;
  owner_e   owner;
  logic     rd_q;
  logic     unused_addr_lsb;

  assign r0 = '{addr:  m0.req_addr,
                we:    m0.req_we,
                wstrb: m0.req_wstrb,
                wdata: m0.req_wdata};
  assign r1 = '{addr:  m1.req_addr,
                we:    m1.req_we,
                wstrb: m1.req_wstrb,
                wdata: m1.req_wdata};

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      gnt0 = 1'b0;
    end else if (m1_lock) begin
      gnt1 = m1.req_valid;
    end else if (force_m1 && m1.req_valid) begin
      gnt1 = 1'b1;
    end else if (m0.req_valid) begin
      gnt0 = 1'b1;
    end else begin
      gnt1 = m1.req_valid;
    end
  end

  assign m0.req_ready = gnt0;
  assign m1.req_ready = gnt1;

  assign win       = gnt1 ? r1 : r0;
  assign ram_en    = gnt0 | gnt1;
  assign ram_we    = (ram_en && win.we) ? win.wstrb : '0;
  assign ram_addr  = win.addr[ADDR_WIDTH-1:2];
  assign ram_wdata = win.wdata;

  assign unused_addr_lsb = ^win.addr[1:0];

  // m1 only accrues wait time while it is actually asking
  tcm_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (m1.req_valid & gnt0),
    .clr      (gnt1 | ~m1.req_valid),
    .force_m1 (force_m1),
    .count    (starve_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_NONE;
      rd_q  <= 1'b0;
    end else begin
      rd_q <= ~win.we;
      if (gnt0) begin
        owner <= OWN_M0;
      end else if (gnt1) begin
        owner <= OWN_M1;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  // reset kills a response already on the wire
  assign m0.rsp_valid = ~rst & (owner == OWN_M0);
  assign m1.rsp_valid = ~rst & (owner == OWN_M1);

  assign m0.rsp_rdata =
    (m0.rsp_valid && rd_q) ? ram_rdata : '0;
  assign m1.rsp_rdata =
    (m1.rsp_valid && rd_q) ? ram_rdata : '0;

endmodule
